// File: rtl/sar_ctrl_pkg.sv
// Shared types and default timing for the SAR conversion controller.
package sar_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAKE,
    ST_EQ,
    ST_AMP,
    ST_LATCH,
    ST_DONE
  } sar_state_t;

  localparam int DEF_NBIT      = 8;
  localparam int DEF_T_WAKE    = 4;
  localparam int DEF_T_EQ      = 2;
  localparam int DEF_T_AMP     = 3;
  localparam int DEF_PWDN_IDLE = 1;

  // Width of the phase counter; wide enough for any practical phase length.
  localparam int CNT_W = 16;

  // A phase of N cycles is loaded as N-1 so the timer expires in its last cycle.
  function automatic logic [CNT_W-1:0] phase_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sar_ctrl_if.sv
// Handshake and analog-control bundle between the SAR controller and its user.
interface sar_ctrl_if #(
  parameter int NBIT = 8
);

  logic            start;
  logic            abort;
  logic            comp;
  logic            pwdn;
  logic            eq;
  logic            latch;
  logic [NBIT-1:0] dac_code;
  logic [NBIT-1:0] dout;
  logic            busy;
  logic            done;

  modport master (
    output start, abort, comp,
    input  pwdn, eq, latch, dac_code, dout, busy, done
  );

  modport slave (
    input  start, abort, comp,
    output pwdn, eq, latch, dac_code, dout, busy, done
  );

endinterface

// File: rtl/sar_phase_timer.sv
// Down-counting phase timer: load a value, count to zero, flag expiry.
module sar_phase_timer
  import sar_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  // Load takes priority; otherwise count down and rest at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/sar_ctrl.sv
// Successive-approximation controller: sequences preamp power, equalize,
// amplify and latch phases per bit and builds the result MSB first.
module sar_ctrl
  import sar_ctrl_pkg::*;
#(
  parameter int NBIT      = DEF_NBIT,
  parameter int T_WAKE    = DEF_T_WAKE,
  parameter int T_EQ      = DEF_T_EQ,
  parameter int T_AMP     = DEF_T_AMP,
  parameter int PWDN_IDLE = DEF_PWDN_IDLE
) (
  input  logic     clk,
  input  logic     rst,
  sar_ctrl_if.slave bus
);

  localparam int              IDX_W    = (NBIT > 1) ? $clog2(NBIT) : 1;
  localparam logic            PWDN_LVL = (PWDN_IDLE != 0);
  localparam logic [NBIT-1:0] MSB_CODE = {1'b1, {(NBIT-1){1'b0}}};

  sar_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [NBIT-1:0]  dac_code;
  logic [NBIT-1:0]  dout;
  logic [NBIT-1:0]  next_code;
  logic             pwdn;
  logic             eq;
  logic             latch;
  logic             busy;
  logic             done;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_expired;

  sar_phase_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // Trial update at the latch: drop the current bit on comp=0, then try the next one.
  always_comb begin
    next_code = dac_code;
    if (!bus.comp) begin
      next_code[idx] = 1'b0;
    end
    if (idx != '0) begin
      next_code[idx - IDX_W'(1)] = 1'b1;
    end
  end

  // Reload the phase timer on every transition into a timed phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          tmr_load = 1'b1;
          tmr_val  = phase_load(T_WAKE);
        end
      end
      ST_WAKE: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = phase_load(T_EQ);
        end
      end
      ST_EQ: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = phase_load(T_AMP);
        end
      end
      ST_LATCH: begin
        if (idx != '0) begin
          tmr_load = 1'b1;
          tmr_val  = phase_load(T_EQ);
        end
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
    if (state != ST_IDLE && bus.abort) begin
      tmr_load = 1'b1;
      tmr_val  = '0;
    end
  end

  // Main FSM; every output is registered and set on entry to the state that owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      dac_code <= '0;
      dout     <= '0;
      pwdn     <= 1'b1;
      eq       <= 1'b0;
      latch    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      eq    <= 1'b0;
      latch <= 1'b0;
      done  <= 1'b0;
      if (state != ST_IDLE && bus.abort) begin
        state    <= ST_IDLE;
        idx      <= '0;
        dac_code <= '0;
        pwdn     <= PWDN_LVL;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            pwdn <= PWDN_LVL;
            if (bus.start) begin
              state    <= ST_WAKE;
              idx      <= IDX_W'(NBIT - 1);
              dac_code <= MSB_CODE;
              pwdn     <= 1'b0;
              busy     <= 1'b1;
            end
          end
          ST_WAKE: begin
            if (tmr_expired) begin
              state <= ST_EQ;
              eq    <= 1'b1;
            end
          end
          ST_EQ: begin
            if (tmr_expired) begin
              state <= ST_AMP;
            end else begin
              eq <= 1'b1;
            end
          end
          ST_AMP: begin
            if (tmr_expired) begin
              state <= ST_LATCH;
              latch <= 1'b1;
            end
          end
          ST_LATCH: begin
            dac_code <= next_code;
            if (idx != '0) begin
              idx   <= idx - IDX_W'(1);
              state <= ST_EQ;
              eq    <= 1'b1;
            end else begin
              state <= ST_DONE;
              dout  <= next_code;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            pwdn  <= PWDN_LVL;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.pwdn     = pwdn;
  assign bus.eq       = eq;
  assign bus.latch    = latch;
  assign bus.dac_code = dac_code;
  assign bus.dout     = dout;
  assign bus.busy     = busy;
  assign bus.done     = done;

endmodule
